control_register_bank: RTL and testbench
========================================

// Module: control_register_bank
// PURPOSE
//  Parametrised CSR bank driving NUM_CH per-channel pipe-enable fields from one master W/R bus.
//  Adds over the single-register version:
//   - registered read path with read_valid
//   - sticky W1C event status with interrupt output
//   - write-lock register
//   - read-only ID register
//   - access-error flagging for unmapped and locked accesses
//  Sits between the host bus decoder and the pipeline datapath enables.
// PARAMETERS
//  ADDR_WIDTH  8      word-address width of address port
//  DATA_WIDTH  32     write_data/read_data width
//  NUM_CH      4      channel count, 1..DATA_WIDTH
//  CH_WIDTH    2      bits per channel enable field, 1..DATA_WIDTH
//  VERSION     32'h0001_0002  value returned by ID register
// PORTS
//  clock         in   1                  rising-edge clock
//  reset         in   1                  async active-low reset
//  address       in   ADDR_WIDTH         word address, sampled with enables
//  write_enable  in   1                  1-cycle write request
//  write_data    in   DATA_WIDTH         write payload
//  read_enable   in   1                  1-cycle read request
//  read_data     out  DATA_WIDTH         registered read data
//  read_valid    out  1                  read_data valid, 1 cycle after read_enable
//  access_error  out  1                  1-cycle pulse: unmapped or locked access
//  event_in      in   NUM_CH             per-channel event pulses (status set)
//  pipe_enable   out  NUM_CH*CH_WIDTH    channel k at [k*CH_WIDTH +: CH_WIDTH]
//  irq           out  1                  registered OR of status bits
// BEHAVIOUR
//  Clock and reset:
//   - one clock.
//   - reset asynchronous active-low; while low all regs and outputs 0, except ID (constant).
//  Address map:
//   - 0..NUM_CH-1: CH[k] R/W; bits CH_WIDTH-1:0 = channel k enable, upper bits read 0.
//   - NUM_CH:   STATUS R/W1C, bits NUM_CH-1:0.
//   - NUM_CH+1: LOCK; bit0 set-only by write of 1; cleared only by reset.
//   - NUM_CH+2: ID, read-only, returns VERSION.
//   - all other addresses unmapped.
//  Writes:
//   - take effect at the clock edge where write_enable=1; pipe_enable updates the next cycle (1-cycle latency).
//   - CH[k] stores write_data[CH_WIDTH-1:0]; wider bits ignored.
//   - LOCK=1: CH writes are dropped and access_error pulses next cycle.
//   - STATUS, LOCK and ID writes are still accepted when LOCK=1. ID writes are ignored, no error.
//  Status:
//   - status[k] sets when event_in[k]=1.
//   - cleared by a STATUS write with write_data[k]=1.
//   - simultaneous set and clear of the same bit: set wins.
//   - irq = registered |status, so it lags status by 1 cycle.
//  Reads:
//   - read_enable samples address; read_data and read_valid are valid on the next cycle.
//   - read_valid is a 1-cycle pulse; read_data holds its value until the next read.
//   - unmapped read: read_data=0, read_valid=1, access_error=1 in the same cycle.
//   - unmapped write: no state change, access_error=1 next cycle.
//  Simultaneous events:
//   - write_enable and read_enable in the same cycle to the same address: read returns the pre-write value.
//   - an error from each in the same cycle gives one access_error pulse.
//  Reset mid-operation: a pending read_valid or access_error is cancelled (forced 0).
//  Back-to-back accesses every cycle are supported; no stall, no ready signal.
// TESTING
//  1. Reset, then read CH0..CH3, STATUS, LOCK -> read_valid each next cycle, data 0;
//     ID read -> 32'h0001_0002.
//  2. Write CH2=32'hFFFF_FFFF -> next cycle pipe_enable[5:4]=2'b11, others 0;
//     CH2 readback 32'h3.
//  3. Pulse event_in=4'b0101 -> STATUS reads 0x5 and irq=1;
//     write STATUS 0x1 in the same cycle as event_in[0] -> STATUS stays 0x5;
//     write 0x5 with no event -> 0x0, irq=0 one cycle later.
//  4. Write LOCK=1, then CH1=0x3 -> CH1 unchanged, access_error pulses once;
//     LOCK write 0 -> LOCK still reads 1.
//  5. Read address 0x20 -> read_data=0, read_valid=1, access_error=1 together;
//     write 0x20 -> no register changes.
//  6. Same-cycle write CH0=0x2 and read CH0 (old value 0x1) -> read returns 0x1,
//     next read returns 0x2; assert reset mid-read -> read_valid stays 0.

Source files
------------

// File: rtl/control_register_bank.sv
// CSR bank: per-channel pipe-enable fields, sticky W1C status with irq, write lock and ID register.
// All bus responses (read data/valid, access error) are registered one cycle after the request.
module control_register_bank #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_CH     = 4,
    parameter int                    CH_WIDTH   = 2,
    parameter logic [DATA_WIDTH-1:0] VERSION    = 32'h0001_0002
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        address,
    input  logic                         write_enable,
    input  logic [DATA_WIDTH-1:0]        write_data,
    input  logic                         read_enable,
    output logic [DATA_WIDTH-1:0]        read_data,
    output logic                         read_valid,
    output logic                         access_error,
    input  logic [NUM_CH-1:0]            event_in,
    output logic [NUM_CH*CH_WIDTH-1:0]   pipe_enable,
    output logic                         irq
);

    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(NUM_CH);
    localparam logic [ADDR_WIDTH-1:0] LOCK_ADDR   = ADDR_WIDTH'(NUM_CH + 1);
    localparam logic [ADDR_WIDTH-1:0] ID_ADDR     = ADDR_WIDTH'(NUM_CH + 2);

    logic [CH_WIDTH-1:0]   ch_q [NUM_CH];
    logic [NUM_CH-1:0]     status_q;
    logic                  lock_q;

    logic                  is_ch, is_status, is_lock, is_id, is_mapped;
    logic                  ch_write, wr_error, rd_error;
    logic [NUM_CH-1:0]     status_clr, status_next;
    logic [DATA_WIDTH-1:0] read_mux;

    assign is_ch     = (address < STATUS_ADDR);
    assign is_status = (address == STATUS_ADDR);
    assign is_lock   = (address == LOCK_ADDR);
    assign is_id     = (address == ID_ADDR);
    assign is_mapped = is_ch | is_status | is_lock | is_id;

    // Locked channel writes are dropped; STATUS/LOCK/ID stay writable under lock.
    assign ch_write = write_enable && is_ch && !lock_q;
    assign wr_error = write_enable && (!is_mapped || (is_ch && lock_q));
    assign rd_error = read_enable && !is_mapped;

    // W1C clear; a same-cycle event on the same bit wins over the clear.
    assign status_clr  = (write_enable && is_status) ? write_data[NUM_CH-1:0] : '0;
    assign status_next = (status_q & ~status_clr) | event_in;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        read_mux = '0;
        if (is_status) read_mux[NUM_CH-1:0] = status_q;
        if (is_lock)   read_mux[0] = lock_q;
        if (is_id)     read_mux = VERSION;
        for (int k = 0; k < NUM_CH; k++) begin
            if (address == ADDR_WIDTH'(k)) read_mux[CH_WIDTH-1:0] = ch_q[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values;
    // this is what makes a same-cycle read return the pre-write contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the channel array is a handful of flops driving live enables, so it is reset
            // explicitly rather than left as uninitialised storage.
            for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
            status_q     <= '0;
            lock_q       <= 1'b0;
            irq          <= 1'b0;
            read_data    <= '0;
            read_valid   <= 1'b0;
            access_error <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_write && address == ADDR_WIDTH'(k)) ch_q[k] <= write_data[CH_WIDTH-1:0];
            end
            if (write_enable && is_lock && write_data[0]) lock_q <= 1'b1;
            status_q     <= status_next;
            irq          <= |status_q;
            read_valid   <= read_enable;
            access_error <= wr_error | rd_error;
            if (read_enable) read_data <= read_mux;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pipe
        assign pipe_enable[k*CH_WIDTH +: CH_WIDTH] = ch_q[k];
    end

endmodule

// File: tb/tb_control_register_bank.sv
// Scoreboard bench for control_register_bank: stimulus updates a behavioural model and queues
// expected per-cycle responses; a monitor pops and compares them after each rising edge.
module tb_control_register_bank;

    localparam int          ADDR_WIDTH = 8;
    localparam int          DATA_WIDTH = 32;
    localparam int          NUM_CH     = 4;
    localparam int          CH_WIDTH   = 2;
    localparam logic [31:0] VERSION    = 32'h0001_0002;

    logic                       clock = 1'b0;
    logic                       reset = 1'b0;
    logic [ADDR_WIDTH-1:0]      address = '0;
    logic                       write_enable = 1'b0;
    logic [DATA_WIDTH-1:0]      write_data = '0;
    logic                       read_enable = 1'b0;
    logic [DATA_WIDTH-1:0]      read_data;
    logic                       read_valid;
    logic                       access_error;
    logic [NUM_CH-1:0]          event_in = '0;
    logic [NUM_CH*CH_WIDTH-1:0] pipe_enable;
    logic                       irq;

    control_register_bank #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_CH(NUM_CH),
        .CH_WIDTH(CH_WIDTH), .VERSION(VERSION)
    ) dut (
        .clock(clock), .reset(reset), .address(address), .write_enable(write_enable),
        .write_data(write_data), .read_enable(read_enable), .read_data(read_data),
        .read_valid(read_valid), .access_error(access_error), .event_in(event_in),
        .pipe_enable(pipe_enable), .irq(irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rv;
        logic        err;
        logic        irq;
        logic [31:0] pe;
    } cyc_t;

    cyc_t        cyc_q[$];
    logic [31:0] rd_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    bit          mon_en     = 1'b1;
    logic [31:0] last_rd    = '0;

    // Reference model state
    int unsigned       ch_m [NUM_CH];
    logic [NUM_CH-1:0] status_m = '0;
    bit                lock_m   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_mapped(input int addr);
        return addr >= 0 && addr <= NUM_CH + 2;
    endfunction

    function automatic logic [31:0] model_read(input int addr);
        if (addr < NUM_CH)      return ch_m[addr];
        if (addr == NUM_CH)     return 32'(status_m);
        if (addr == NUM_CH + 1) return 32'(lock_m);
        if (addr == NUM_CH + 2) return VERSION;
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_pipe();
        logic [31:0] pe = '0;
        for (int k = 0; k < NUM_CH; k++) pe = pe | (ch_m[k] << (k * CH_WIDTH));
        return pe;
    endfunction

    // One bus cycle: drive inputs, predict the response to the coming edge, then advance the model.
    task automatic issue(input bit we, input bit re, input int addr, input logic [31:0] wd,
                         input logic [NUM_CH-1:0] ev);
        cyc_t e;
        @(negedge clock);
        write_enable = we;
        read_enable  = re;
        address      = ADDR_WIDTH'(addr);
        write_data   = wd;
        event_in     = ev;
        if (re) rd_q.push_back(model_read(addr));
        e.rv  = re;
        e.err = (re && !model_mapped(addr)) ||
                (we && (!model_mapped(addr) || (addr < NUM_CH && lock_m)));
        e.irq = (status_m != 0);
        if (we) begin
            if (addr < NUM_CH && !lock_m) ch_m[addr] = wd % (1 << CH_WIDTH);
            if (addr == NUM_CH)           status_m = status_m & ~wd[NUM_CH-1:0];
            if (addr == NUM_CH + 1 && wd[0]) lock_m = 1'b1;
        end
        status_m = status_m | ev;
        e.pe = model_pipe();
        cyc_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 0, 32'h0, '0);
    endtask

    task automatic rd(input int addr);
        issue(1'b0, 1'b1, addr, 32'h0, '0);
    endtask

    task automatic wr(input int addr, input logic [31:0] wd);
        issue(1'b1, 1'b0, addr, wd, '0);
    endtask

    // Monitor: compares each post-edge cycle against the oldest queued expectation.
    initial begin
        cyc_t e;
        logic [31:0] exp_rd;
        forever begin
            @(posedge clock);
            #1;
            if (mon_en && cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("read_valid", 32'(read_valid), 32'(e.rv));
                check("access_error", 32'(access_error), 32'(e.err));
                check("irq", 32'(irq), 32'(e.irq));
                check("pipe_enable", 32'(pipe_enable), e.pe);
                if (read_valid) begin
                    if (rd_q.size() == 0) begin
                        check("read_unexpected", 32'h1, 32'h0);
                    end else begin
                        exp_rd = rd_q.pop_front();
                        check("read_data", read_data, exp_rd);
                        last_rd = exp_rd;
                    end
                end else begin
                    check("read_data_hold", read_data, last_rd);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int addr;
        logic [31:0] wd;
        for (int k = 0; k < NUM_CH; k++) ch_m[k] = 0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_pipe_enable", 32'(pipe_enable), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_read_valid", 32'(read_valid), 32'h0);
        check("rst_access_error", 32'(access_error), 32'h0);
        check("rst_read_data", read_data, 32'h0);
        reset = 1'b1;

        // Reset readback of every mapped register
        for (int a = 0; a <= NUM_CH + 2; a++) rd(a);

        // Channel write: only the CH_WIDTH low bits land
        wr(2, 32'hFFFF_FFFF);
        rd(2);
        idle(1);

        // Sticky status, set-wins-over-clear, W1C, irq lag
        issue(1'b0, 1'b0, 0, 32'h0, 4'b0101);
        rd(NUM_CH);
        issue(1'b1, 1'b0, NUM_CH, 32'h1, 4'b0001);
        rd(NUM_CH);
        wr(NUM_CH, 32'h5);
        rd(NUM_CH);
        idle(2);

        // Same-cycle write and read of CH0 returns the old value
        wr(0, 32'h1);
        issue(1'b1, 1'b1, 0, 32'h2, '0);
        rd(0);

        // Unmapped read and write
        rd(32'h20);
        wr(32'h20, 32'hFFFF_FFFF);
        for (int a = 0; a <= NUM_CH + 2; a++) rd(a);

        // Random traffic, lock bit held clear so channel writes keep landing
        for (int i = 0; i < 300; i++) begin
            addr = ($urandom_range(0, 15) < 11) ? int'($urandom_range(0, 9)) : int'($urandom_range(7, 255));
            wd = $urandom;
            if (addr == NUM_CH + 1) wd[0] = 1'b0;
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, wd,
                  ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0);
        end

        // Lock: channel writes dropped with an error, lock cannot be cleared
        wr(NUM_CH + 1, 32'h1);
        rd(1);
        wr(1, 32'h3);
        rd(1);
        wr(NUM_CH + 1, 32'h0);
        rd(NUM_CH + 1);
        wr(NUM_CH, 32'hF);
        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 9)),
                  $urandom, ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0);
        end
        idle(3);
        @(posedge clock);
        #2;
        check("queue_drained", 32'(cyc_q.size() + rd_q.size()), 32'h0);
        mon_en = 1'b0;

        // Reset arriving while a read and an erroring access are pending cancels both responses
        @(negedge clock);
        read_enable  = 1'b1;
        write_enable = 1'b1;
        address      = 8'h20;
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("mid_rst_read_valid", 32'(read_valid), 32'h0);
        check("mid_rst_access_error", 32'(access_error), 32'h0);
        check("mid_rst_pipe_enable", 32'(pipe_enable), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_read_data", read_data, 32'h0);
        @(negedge clock);
        read_enable  = 1'b0;
        write_enable = 1'b0;
        reset        = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_read_valid", 32'(read_valid), 32'h0);
        check("post_rst_access_error", 32'(access_error), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
